// File: rtl/shift_unit.sv
// Multi-cycle shift/rotate unit: moves the working register by up to STEP bits
// per clock under a start/done handshake.
//   state | meaning
//   IDLE  | waiting for start
//   SHIFT | shifting the working register, busy=1
//   DONE  | one-cycle done pulse; result valid, new start accepted
module shift_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand,
    input  logic [AMT_W-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             illegal_op
);

    localparam logic [2:0] OP_SHR  = 3'b000;
    localparam logic [2:0] OP_SHRA = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;

    localparam logic [AMT_W:0] STEP_V  = (AMT_W+1)'(STEP);
    localparam logic [AMT_W:0] WIDTH_V = (AMT_W+1)'(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] work;
    logic [AMT_W-1:0] remaining;
    logic             sign;
    logic [2:0]       op_q;
    logic             illegal_q;

    logic             accept;
    logic             op_legal;
    logic [AMT_W:0]   step_amt;
    logic [AMT_W:0]   step_inv;
    logic [WIDTH-1:0] sign_fill;
    logic [WIDTH-1:0] shifted;

    assign accept   = start && (state == IDLE || state == DONE);
    assign op_legal = (op <= OP_ROL);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept)
                    state_nxt = (amount != '0 && op_legal) ? SHIFT : DONE;
                else
                    state_nxt = IDLE;
            end
            SHIFT: begin
                if ({1'b0, remaining} <= STEP_V) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A shift by WIDTH yields zero, so step_amt=0 degrades cleanly to a pass-through.
    always_comb begin
        step_amt  = ({1'b0, remaining} > STEP_V) ? STEP_V : {1'b0, remaining};
        step_inv  = WIDTH_V - step_amt;
        sign_fill = sign ? ~({WIDTH{1'b1}} >> step_amt) : '0;
        shifted   = work;
        case (op_q)
            OP_SHR:  shifted = work >> step_amt;
            OP_SHRA: shifted = (work >> step_amt) | sign_fill;
            OP_SHL:  shifted = work << step_amt;
            OP_ROR:  shifted = (work >> step_amt) | (work << step_inv);
            OP_ROL:  shifted = (work << step_amt) | (work >> step_inv);
            default: shifted = work;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            work      <= '0;
            remaining <= '0;
            sign      <= 1'b0;
            op_q      <= OP_SHR;
            illegal_q <= 1'b0;
        end else if (accept) begin
            work      <= operand;
            remaining <= amount;
            sign      <= operand[WIDTH-1];
            op_q      <= op;
            illegal_q <= !op_legal;
        end else if (state == SHIFT) begin
            work      <= shifted;
            remaining <= remaining - step_amt[AMT_W-1:0];
        end
    end

    assign busy       = (state == SHIFT);
    assign done       = (state == DONE);
    assign result     = work;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit: stimulus pushes expected result/latency into a
// scoreboard, a monitor pops and compares on every done pulse.
module tb_shift_unit;

    logic        clock;
    logic        clear;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operand;
    logic [4:0]  amount;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        illegal_op;

    typedef struct {
        logic [31:0] res;
        logic        ill;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    shift_unit #(.WIDTH(32), .STEP(4)) dut (
        .clock      (clock),
        .clear      (clear),
        .start      (start),
        .op         (op),
        .operand    (operand),
        .amount     (amount),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .illegal_op (illegal_op)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (clear === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", result, e.res);
                check("illegal_op", {31'b0, illegal_op}, {31'b0, e.ill});
                check("latency", cyc, e.cyc);
                check("busy_at_done", {31'b0, busy}, 32'd0);
            end
        end
    end

    // Caller is at a negedge; accept happens on the next posedge.
    task automatic issue(input logic [2:0] o, input logic [31:0] v, input logic [4:0] a,
                         input logic [31:0] res, input logic ill, input int n);
        op      = o;
        operand = v;
        amount  = a;
        start   = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        sb.push_back('{res: res, ill: ill, cyc: cyc + n});
    endtask

    task automatic wait_done(output int busy_cnt);
        bit seen = 0;
        busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) busy_cnt++;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 100 cycles");
        end
    endtask

    task automatic run_vec(input logic [2:0] o, input logic [31:0] v, input logic [4:0] a,
                           input logic [31:0] res, input logic ill, input int n);
        int bc;
        issue(o, v, a, res, ill, n);
        wait_done(bc);
        check("busy_cycles", bc, n);
        @(negedge clock);
    endtask

    initial begin
        int bc;
        clear   = 1'b0;
        start   = 1'b0;
        op      = 3'b000;
        operand = '0;
        amount  = '0;
        #12;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_illegal", {31'b0, illegal_op}, 32'd0);
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);

        run_vec(3'b001, 32'hFFFF_FFF6, 5'd2,  32'hFFFF_FFFD, 1'b0, 1);
        run_vec(3'b000, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 8);
        run_vec(3'b001, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 8);
        run_vec(3'b100, 32'h8000_0001, 5'd4,  32'h0000_0018, 1'b0, 1);
        run_vec(3'b011, 32'h0000_0003, 5'd1,  32'h8000_0001, 1'b0, 1);
        run_vec(3'b010, 32'h0000_000F, 5'd28, 32'hF000_0000, 1'b0, 7);
        run_vec(3'b010, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0, 0);
        run_vec(3'b111, 32'hDEAD_BEEF, 5'd5,  32'hDEAD_BEEF, 1'b1, 0);
        run_vec(3'b011, 32'h1234_5678, 5'd8,  32'h7812_3456, 1'b0, 2);
        run_vec(3'b100, 32'h1234_5678, 5'd12, 32'h4567_8123, 1'b0, 3);
        run_vec(3'b001, 32'h7000_0000, 5'd5,  32'h0380_0000, 1'b0, 2);
        run_vec(3'b101, 32'h0000_00AA, 5'd0,  32'h0000_00AA, 1'b1, 0);

        // start while busy is dropped; start during done is accepted back-to-back
        issue(3'b010, 32'h0000_0001, 5'd9, 32'h0000_0200, 1'b0, 3);
        @(negedge clock);
        op      = 3'b000;
        operand = 32'hFFFF_FFFF;
        amount  = 5'd1;
        start   = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done(bc);
        issue(3'b011, 32'h0000_000F, 5'd4, 32'hF000_0000, 1'b0, 1);
        wait_done(bc);
        check("b2b_busy_cycles", bc, 1);
        @(negedge clock);

        // asynchronous clear mid-shift aborts without a done pulse
        issue(3'b001, 32'h8000_0000, 5'd20, 32'hFFFF_F800, 1'b0, 5);
        @(negedge clock);
        @(posedge clock);
        #2;
        clear = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        void'(sb.pop_back());
        repeat (3) @(negedge clock);
        clear = 1'b1;
        repeat (4) @(negedge clock);
        run_vec(3'b001, 32'h8000_0000, 5'd20, 32'hFFFF_F800, 1'b0, 5);

        repeat (3) @(negedge clock);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
